output_port_arbiter: RTL and testbench
======================================

Name: output_port_arbiter

Overview:
- Round-robin read scheduler for the leaf's output-port cluster.
- Watches the per-port empty flags and pulses a one-hot rd_en_sel into the chosen Output_Port FIFO.
- Captures that port's internal_out packet and presents it to the leaf-side NoC injection interface with a valid/ready handshake.
- Sits between Output_Port_Cluster_* and the leaf interface's upstream packet mux. It is the only reader of the output-port FIFOs.

Parameters:
- PACKET_BITS, 97, width of one NoC packet.
- NUM_OUT_PORTS, 7, number of output ports arbitrated (1..16).
- CNT_BITS, 32, width of the sent-packet counter.
- localparam IDX_BITS = max(1, clog2(NUM_OUT_PORTS)).

Ports:
- clk  in  1  BFT/NoC clock; single clock domain.
- reset  in  1  synchronous, active-high.
- empty  in  NUM_OUT_PORTS  per-port FIFO empty flag from the output-port cluster.
- internal_out  in  PACKET_BITS*NUM_OUT_PORTS  per-port FIFO read data; port i occupies bits [PACKET_BITS*(i+1)-1 : PACKET_BITS*i].
- rd_en_sel  out  NUM_OUT_PORTS  one-hot FIFO pop, registered.
- stall  in  1  when high, no new grant is issued; a transaction already in flight completes.
- out_packet  out  PACKET_BITS  captured packet, registered.
- out_valid  out  1  out_packet is valid.
- out_ready  in  1  downstream accepts out_packet this cycle.
- grant_idx  out  IDX_BITS  index of the port whose packet is in flight or held.
- busy  out  1  high in any state other than IDLE.
- pkt_sent_cnt  out  CNT_BITS  count of completed handshakes.

Behaviour:
- Reset (clk edge with reset=1) sets:
  - state=IDLE; rd_en_sel=0; out_valid=0; out_packet=0; grant_idx=0; busy=0; pkt_sent_cnt=0;
  - rr_ptr=NUM_OUT_PORTS-1, so port 0 has first priority.
- FSM states: IDLE, READ, CAPT, SEND.
- IDLE, at cycle t with stall=0 and req=~empty nonzero:
  - winner = first requesting index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_OUT_PORTS.
  - Register grant_idx=winner, rr_ptr=winner, rd_en_sel=onehot(winner); go to READ.
  - If stall=1 or req=0, stay in IDLE with rd_en_sel=0.
- READ (cycle t+1): rd_en_sel is high for exactly this one cycle. The next-state logic clears it. Go to CAPT.
- CAPT (cycle t+2):
  - FIFO read latency is fixed at 1, so internal_out[grant_idx] is valid this cycle.
  - Latch it into out_packet, set out_valid=1, go to SEND.
- SEND (from cycle t+3):
  - out_valid=1; out_packet and grant_idx are held stable.
  - On out_valid & out_ready: at that edge, out_valid=0, pkt_sent_cnt+=1 (wraps modulo 2^CNT_BITS), state=IDLE.
  - Otherwise stay in SEND indefinitely.
- Throughput: one packet per 4 cycles minimum with out_ready tied high. Latency from request to out_valid is 3 cycles.
- busy = (state != IDLE). It is registered together with the state.
- Arbitration boundary cases:
  - Empty flags are only sampled in IDLE. Empty can only deassert→assert through our own pop, so a grant never targets an empty FIFO.
  - stall asserted during READ/CAPT/SEND has no effect on the current transaction. It only blocks the next IDLE grant.
  - Single requester: that requester wins regardless of rr_ptr.
  - NUM_OUT_PORTS=1: rr_ptr and grant_idx are constant 0 and behaviour is otherwise unchanged.
- out_ready asserted while out_valid=0 is ignored.
- Reset mid-operation:
  - Same as power-on reset.
  - A packet already popped (READ/CAPT/SEND) is discarded. This loss is accepted.
  - rd_en_sel drops in the reset cycle.

Decomposition:
- Shared package (leaf_if_pkg): state encoding constants, OUT_PORTS_REG_BITS formula, and the PACKET_BITS default.
- One sub-module: rr_priority_select (req, ptr → one-hot grant + index), purely combinational. It is reusable by the input-port side.

Test Plan:
- Single port: N=7, empty=7'b1111011, out_ready=1.
  - rd_en_sel=7'b0000100 one cycle after the request, and only one pulse.
  - out_valid 3 cycles after the request, with out_packet equal to port 2 data.
  - pkt_sent_cnt=1.
- Fairness: all 7 ports non-empty continuously, 14 packets.
  - Grant order is 0,1,...,6,0,...,6.
  - Never two rd_en_sel bits high; no rd_en to an empty port.
- Backpressure: out_ready=0 for 10 cycles in SEND.
  - out_valid, out_packet and grant_idx stay constant.
  - No further rd_en_sel.
  - Handshake on the 11th cycle, then return to IDLE.
- Stall: stall=1 raised during CAPT.
  - The current packet completes.
  - No new grant while stall=1; a grant occurs 1 cycle after stall drops.
- Reset in SEND: all outputs go to their reset values next edge; rr_ptr resets, so port 0 wins the next arbitration.
- Counter wrap: CNT_BITS=4, 17 handshakes → pkt_sent_cnt=1.

Source files
------------

// File: rtl/leaf_if_pkg.sv
// leaf_if_pkg: shared state encoding and sizing helpers for the leaf interface blocks
package leaf_if_pkg;
  localparam int PACKET_BITS_DEF = 97;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } arb_state_e;
  function automatic int out_ports_reg_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: picks the first requester after ptr, wrapping modulo N
module rr_priority_select #(
  parameter int N = 7,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int best;
  int d;
  // keep the requester with the smallest circular distance past ptr
  always_comb begin
    gnt = '0;
    idx = '0;
    best = N;
    d = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - 1 - int'(ptr)) % N;
      if (req[i] && d < best) begin
        best = d;
        idx = IW'(i);
        gnt = '0;
        gnt[i] = 1'b1;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin reader of the output-port FIFOs feeding the leaf NoC injection port
module output_port_arbiter
  import leaf_if_pkg::*;
#(
  parameter int PACKET_BITS = PACKET_BITS_DEF,
  parameter int NUM_OUT_PORTS = 7,
  parameter int CNT_BITS = 32,
  localparam int IDX_BITS = out_ports_reg_bits(NUM_OUT_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_OUT_PORTS-1:0]         empty,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] internal_out,
  output logic [NUM_OUT_PORTS-1:0]         rd_en_sel,
  input  logic                             stall,
  output logic [PACKET_BITS-1:0]           out_packet,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDX_BITS-1:0]              grant_idx,
  output logic                             busy,
  output logic [CNT_BITS-1:0]              pkt_sent_cnt
);
  arb_state_e state_q, state_d;
  logic [NUM_OUT_PORTS-1:0] rd_en_sel_q, rd_en_sel_d;
  logic [PACKET_BITS-1:0] out_packet_q, out_packet_d;
  logic out_valid_q, out_valid_d;
  logic [IDX_BITS-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic busy_q, busy_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_OUT_PORTS-1:0] win_gnt;
  logic [IDX_BITS-1:0] win_idx;
  logic win_any;
  logic [PACKET_BITS-1:0] pkts [NUM_OUT_PORTS];

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_slice
    assign pkts[g] = internal_out[PACKET_BITS*g +: PACKET_BITS];
  end

  rr_priority_select #(.N(NUM_OUT_PORTS), .IW(IDX_BITS)) u_sel (
    .req(~empty),
    .ptr(rr_ptr_q),
    .gnt(win_gnt),
    .idx(win_idx),
    .any(win_any)
  );

  // grant in IDLE, pop for one cycle, capture the FIFO data a cycle later, then hold until accepted
  always_comb begin
    state_d = state_q;
    rd_en_sel_d = '0;
    out_packet_d = out_packet_q;
    out_valid_d = out_valid_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (!stall && win_any) begin
        state_d = READ;
        grant_idx_d = win_idx;
        rr_ptr_d = win_idx;
        rd_en_sel_d = win_gnt;
      end
      READ: state_d = CAPT;
      CAPT: begin
        out_packet_d = pkts[grant_idx_q];
        out_valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (out_ready) begin
        out_valid_d = 1'b0;
        cnt_d = cnt_q + CNT_BITS'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and all outputs are registered; reset discards any in-flight packet
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_en_sel_q <= '0;
      out_packet_q <= '0;
      out_valid_q <= 1'b0;
      grant_idx_q <= '0;
      rr_ptr_q <= IDX_BITS'(NUM_OUT_PORTS - 1);
      busy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rd_en_sel_q <= rd_en_sel_d;
      out_packet_q <= out_packet_d;
      out_valid_q <= out_valid_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_en_sel = rd_en_sel_q;
  assign out_packet = out_packet_q;
  assign out_valid = out_valid_q;
  assign grant_idx = grant_idx_q;
  assign busy = busy_q;
  assign pkt_sent_cnt = cnt_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed checks of the output-port arbiter against a small FIFO model
module tb_output_port_arbiter;
  logic clk;
  logic reset;
  logic stall;
  logic out_ready;
  logic [6:0] empty;
  logic [7*97-1:0] internal_out;
  logic [6:0] rd_en_sel;
  logic [96:0] out_packet;
  logic out_valid;
  logic [2:0] grant_idx;
  logic busy;
  logic [3:0] pkt_sent_cnt;
  int pushes [7] = '{default: 0};
  int pops [7] = '{default: 0};
  logic [96:0] fifo_data [7] = '{default: '0};
  logic [3:0] exp_cnt;
  int n_checks = 0;
  int n_fail = 0;

  output_port_arbiter #(.PACKET_BITS(97), .NUM_OUT_PORTS(7), .CNT_BITS(4)) dut (
    .clk(clk),
    .reset(reset),
    .empty(empty),
    .internal_out(internal_out),
    .rd_en_sel(rd_en_sel),
    .stall(stall),
    .out_packet(out_packet),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grant_idx(grant_idx),
    .busy(busy),
    .pkt_sent_cnt(pkt_sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [96:0] mk(input int p, input int k);
    return {33'h1DEADBEEF, 32'(p), 32'(k)};
  endfunction

  always_comb begin
    for (int i = 0; i < 7; i++) begin
      empty[i] = (pushes[i] <= pops[i]);
      internal_out[97*i +: 97] = fifo_data[i];
    end
  end

  // FIFO model: read data appears one cycle after the pop
  always @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      if (rd_en_sel[i]) begin
        fifo_data[i] <= mk(i, pops[i]);
        pops[i] <= pops[i] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_cnt = 4'd0;
    n_checks++;
    if ({rd_en_sel, out_valid, busy, grant_idx, pkt_sent_cnt} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=0", {rd_en_sel, out_valid, busy, grant_idx, pkt_sent_cnt});
    end
    n_checks++;
    if (out_packet !== 97'd0) begin
      n_fail++;
      $display("FAIL reset_packet got=%h exp=0", out_packet);
    end
  endtask

  task automatic test_single();
    int k;
    k = pops[2];
    out_ready = 1'b1;
    pushes[2] = pops[2] + 1;
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b0000100 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rd_en got=%b busy=%b exp=0000100 busy=1", rd_en_sel, busy);
    end
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse got=%b valid=%b exp=0 valid=0", rd_en_sel, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_packet !== mk(2, k) || grant_idx !== 3'd2) begin
      n_fail++;
      $display("FAIL single_capture got v=%b pkt=%h idx=%0d exp v=1 pkt=%h idx=2", out_valid, out_packet, grant_idx, mk(2, k));
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (out_valid !== 1'b0 || pkt_sent_cnt !== exp_cnt || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done got v=%b cnt=%0d busy=%b exp v=0 cnt=%0d busy=0", out_valid, pkt_sent_cnt, busy, exp_cnt);
    end
    tick();
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_repeat got=%b busy=%b exp=0 busy=0", rd_en_sel, busy);
    end
  endtask

  task automatic test_fairness();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 4'd0;
    for (int i = 0; i < 7; i++) pushes[i] = pops[i] + 100;
    for (int p = 0; p < 14; p++) begin
      int port;
      int k;
      logic [6:0] oh;
      port = p % 7;
      k = pops[port];
      oh = 7'(1 << port);
      tick();
      n_checks++;
      if (rd_en_sel !== oh) begin
        n_fail++;
        $display("FAIL fair_grant[%0d] got=%b exp=%b", p, rd_en_sel, oh);
      end
      tick();
      n_checks++;
      if (rd_en_sel !== 7'b0) begin
        n_fail++;
        $display("FAIL fair_pulse[%0d] got=%b exp=0", p, rd_en_sel);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_packet !== mk(port, k) || grant_idx !== 3'(port)) begin
        n_fail++;
        $display("FAIL fair_data[%0d] got v=%b pkt=%h idx=%0d exp v=1 pkt=%h idx=%0d", p, out_valid, out_packet, grant_idx, mk(port, k), port);
      end
      if (p == 13) for (int i = 0; i < 7; i++) pushes[i] = pops[i];
      tick();
      exp_cnt++;
    end
    n_checks++;
    if (pkt_sent_cnt !== exp_cnt || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_count got=%0d v=%b exp=%0d v=0", pkt_sent_cnt, out_valid, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int k;
    k = pops[4];
    out_ready = 1'b0;
    pushes[4] = pops[4] + 1;
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b0010000) begin
      n_fail++;
      $display("FAIL bp_grant got=%b exp=0010000", rd_en_sel);
    end
    tick();
    tick();
    for (int c = 1; c <= 10; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_packet !== mk(4, k) || grant_idx !== 3'd4 || rd_en_sel !== 7'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b pkt=%h idx=%0d rd=%b exp v=1 pkt=%h idx=4 rd=0", c, out_valid, out_packet, grant_idx, rd_en_sel, mk(4, k));
      end
      if (c < 10) tick();
    end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || pkt_sent_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL bp_release got v=%b busy=%b cnt=%0d exp v=0 busy=0 cnt=%0d", out_valid, busy, pkt_sent_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall();
    int k1;
    int k3;
    k1 = pops[1];
    k3 = pops[3];
    out_ready = 1'b1;
    pushes[1] = pops[1] + 1;
    pushes[3] = pops[3] + 1;
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b0000010) begin
      n_fail++;
      $display("FAIL stall_first_grant got=%b exp=0000010", rd_en_sel);
    end
    tick();
    stall = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_packet !== mk(1, k1)) begin
      n_fail++;
      $display("FAIL stall_inflight got v=%b pkt=%h exp v=1 pkt=%h", out_valid, out_packet, mk(1, k1));
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (out_valid !== 1'b0 || pkt_sent_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL stall_complete got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, pkt_sent_cnt, exp_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (rd_en_sel !== 7'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_block[%0d] got rd=%b busy=%b exp rd=0 busy=0", c, rd_en_sel, busy);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b0001000) begin
      n_fail++;
      $display("FAIL stall_resume got=%b exp=0001000", rd_en_sel);
    end
    tick();
    tick();
    n_checks++;
    if (out_packet !== mk(3, k3) || grant_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL stall_second got pkt=%h idx=%0d exp pkt=%h idx=3", out_packet, grant_idx, mk(3, k3));
    end
    tick();
    exp_cnt++;
  endtask

  task automatic test_reset_in_send();
    int k0;
    int k6;
    out_ready = 1'b0;
    pushes[5] = pops[5] + 1;
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b0100000) begin
      n_fail++;
      $display("FAIL rst_send_grant got=%b exp=0100000", rd_en_sel);
    end
    tick();
    tick();
    pushes[0] = pops[0] + 1;
    pushes[6] = pops[6] + 1;
    k0 = pops[0];
    k6 = pops[6];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    exp_cnt = 4'd0;
    n_checks++;
    if ({rd_en_sel, out_valid, busy, grant_idx, pkt_sent_cnt} !== 16'd0 || out_packet !== 97'd0) begin
      n_fail++;
      $display("FAIL rst_send_outputs got ctrl=%b pkt=%h exp 0", {rd_en_sel, out_valid, busy, grant_idx, pkt_sent_cnt}, out_packet);
    end
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b0000001) begin
      n_fail++;
      $display("FAIL rst_send_port0 got=%b exp=0000001", rd_en_sel);
    end
    tick();
    tick();
    n_checks++;
    if (out_packet !== mk(0, k0)) begin
      n_fail++;
      $display("FAIL rst_send_pkt0 got=%h exp=%h", out_packet, mk(0, k0));
    end
    tick();
    exp_cnt++;
    tick();
    n_checks++;
    if (rd_en_sel !== 7'b1000000) begin
      n_fail++;
      $display("FAIL rst_send_port6 got=%b exp=1000000", rd_en_sel);
    end
    tick();
    tick();
    n_checks++;
    if (out_packet !== mk(6, k6) || grant_idx !== 3'd6) begin
      n_fail++;
      $display("FAIL rst_send_pkt6 got pkt=%h idx=%0d exp pkt=%h idx=6", out_packet, grant_idx, mk(6, k6));
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (pkt_sent_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL rst_send_count got=%0d exp=%0d", pkt_sent_cnt, exp_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    exp_cnt = 4'd0;
    pushes[2] = pops[2] + 17;
    for (int p = 0; p < 17; p++) begin
      tick();
      n_checks++;
      if (rd_en_sel !== 7'b0000100) begin
        n_fail++;
        $display("FAIL wrap_grant[%0d] got=%b exp=0000100", p, rd_en_sel);
      end
      tick();
      tick();
      tick();
      exp_cnt++;
      n_checks++;
      if (pkt_sent_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL wrap_count[%0d] got=%0d exp=%0d", p, pkt_sent_cnt, exp_cnt);
      end
    end
    n_checks++;
    if (pkt_sent_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_final got=%0d exp=1", pkt_sent_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    out_ready = 1'b0;
    exp_cnt = 4'd0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_stall();
    test_reset_in_send();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
